sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single external asynchronous SRAM (20-bit address, 48-bit data, active-low ce/oen/wen) between three requesters: VGA scanout, GPU and CPU.
- Sequences each SRAM access with programmable read/write strobe lengths, drives the data-bus output enable, and returns read data with a one-cycle ack.
- Sits in soc between the bus masters and the sram_* pins. The top level builds the tristate from sram_dq_o/sram_dq_oe.

Parameters:
- ADDR_W, 20, SRAM word address width
- DATA_W, 48, SRAM data width
- READ_CYCLES, 2, cycles oen/ce held low per read (>=1)
- WRITE_CYCLES, 2, cycles wen/ce held low per write (>=1)
- VGA_MAX_BURST, 8, consecutive VGA grants before a pending CPU/GPU request is forced in (only with SRAM_ARB_STARVE_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- vga_req  in  1  VGA read request, held until vga_ack
- vga_addr  in  ADDR_W  VGA read address
- vga_ack  out  1  one-cycle completion pulse
- gpu_req, cpu_req  in  1  requests, held until own ack
- gpu_we, cpu_we  in  1  1=write, 0=read
- gpu_addr, cpu_addr  in  ADDR_W  address
- gpu_wdata, cpu_wdata  in  DATA_W  write data
- gpu_ack, cpu_ack  out  1  one-cycle completion pulse
- rdata  out  DATA_W  shared read data, valid in the ack cycle of a read
- sram_addr  out  ADDR_W  SRAM address
- sram_dq_o  out  DATA_W  SRAM write data
- sram_dq_oe  out  1  1 = drive sram_dq
- sram_dq_i  in  DATA_W  SRAM read data
- sram_ce, sram_oen, sram_wen  out  1  active-low strobes

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Registers: all outputs are registered.
- Reset values: state=IDLE; sram_ce/oen/wen=1; sram_dq_oe=0; sram_addr=0; sram_dq_o=0; rdata=0; all acks=0; rr_last=GPU, so CPU wins the first tie.
- FSM states: IDLE, RD, WR, DONE.
- IDLE, no request pending: stay in IDLE.
- IDLE, request pending: pick the winner, then latch addr, wdata, we and owner id.
  - Read winner: go to RD with ce=0 and oen=0.
  - Write winner: go to WR with ce=0, wen=0 and dq_oe=1.
  - Counter loads READ_CYCLES-1 or WRITE_CYCLES-1.
- Priority: VGA has fixed highest priority. CPU and GPU round-robin: on a tie, grant the one that is not rr_last. rr_last updates only on CPU/GPU grants.
- RD: decrement the counter. At 0, capture sram_dq_i into rdata, set ce=1 and oen=1, go to DONE.
- WR: decrement the counter. At 0, set wen=1 and ce=1, keep dq_oe=1 (data hold), go to DONE.
- DONE: pulse the owner's ack for one cycle, set dq_oe=0, go to IDLE.
- Timing: a request sampled in IDLE at cycle N gets its ack at cycle N+READ_CYCLES+1 (read) or N+WRITE_CYCLES+1 (write). Back-to-back throughput is one access per X+2 cycles.
- Request rules: a requester deasserts req (or presents the next request) in the cycle after ack. Because IDLE follows DONE, the same request is never double-granted. Address, data and we are don't-care once latched.
- Illegal drop: req dropped before ack is illegal. The access still completes and ack still pulses.
- Bus contention: dq_oe is never 1 while oen=0. Write-to-read has at least one DONE cycle with oen=1 and dq_oe=0.
- rdata: held until the next read capture. Writes do not alter rdata.
- Reset mid-access: takes effect at the next edge. Strobes go to 1 and dq_oe to 0, no ack issues, the access is lost.

Optional Feature:
- Macro: SRAM_ARB_STARVE_EN.
- Defined:
  - A counter vga_run increments on each VGA grant.
  - vga_run clears on any CPU/GPU grant or when IDLE has no VGA request.
  - When vga_run==VGA_MAX_BURST and CPU or GPU is pending, the next grant goes to CPU/GPU (round-robin) even if vga_req=1.
- Undefined: VGA is strictly highest priority and can starve CPU/GPU indefinitely.

Decomposition:
- Header sram_arb_defs.vh holds:
  - state encodings (IDLE=2'd0, RD=2'd1, WR=2'd2, DONE=2'd3);
  - owner ids (OWN_VGA=2'd0, OWN_GPU=2'd1, OWN_CPU=2'd2).
- One combinational sub-module, sram_arb_sel: inputs are the three reqs, rr_last and the force-non-VGA flag; outputs are the one-hot grant and owner id.
- The FSM, counter and datapath live in sram_arbiter.

Test Plan:
- CPU read addr 20'h00010, READ_CYCLES=2, sram_dq_i=48'h0123456789AB: oen low exactly 2 cycles, cpu_ack at req+3, rdata=48'h0123456789AB.
- GPU write addr 20'h00020, data 48'hA5A5A5A5A5A5, WRITE_CYCLES=2: wen low 2 cycles, dq_oe high 3 cycles, sram_dq_o stable throughout, gpu_ack at req+3.
- CPU, GPU and VGA requests in the same cycle, continuous: grant order VGA, then CPU, then GPU on release of VGA. Continuous CPU+GPU alternate CPU, GPU, CPU, GPU.
- CPU write immediately followed by VGA read: at least one cycle with dq_oe=0 before oen falls; never dq_oe=1 with oen=0.
- rst asserted in the 2nd RD cycle: next cycle ce/oen/wen=1, dq_oe=0, no ack. A fresh request afterwards completes normally.
- With SRAM_ARB_STARVE_EN and VGA_MAX_BURST=8, vga_req held high and cpu_req high: cpu_ack after 8 VGA acks, then VGA resumes. Without the macro, no cpu_ack in 100 accesses.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_arbiter_pkg
// Shared encodings for the SRAM arbiter: FSM state encoding, requester owner
// ids and the bit positions of the one-hot grant vector.
// -----------------------------------------------------------------------------
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_VGA = 2'd0,
        OWN_GPU = 2'd1,
        OWN_CPU = 2'd2
    } owner_t;

    // Bit positions inside the one-hot grant vector (same order as owner ids).
    localparam int GNT_VGA = 0;
    localparam int GNT_GPU = 1;
    localparam int GNT_CPU = 2;

    // Width of a down-counter that must hold values 0 .. n-1 (at least 1 bit).
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/sram_arb_sel.sv
// -----------------------------------------------------------------------------
// sram_arb_sel
// Combinational winner selection for the SRAM arbiter.
//   vga_req, gpu_req, cpu_req : pending requests
//   rr_last                   : last CPU/GPU owner granted (round-robin state)
//   force_cg                  : VGA burst limit reached, let CPU/GPU in first
//   grant                     : one-hot grant, all zero when nothing pends
//   owner                     : owner id of the winner (OWN_VGA when idle)
// VGA has fixed top priority unless force_cg is set and CPU/GPU is pending;
// CPU and GPU share the rest round-robin.
// -----------------------------------------------------------------------------
module sram_arb_sel
    import sram_arbiter_pkg::*;
(
    input  logic       vga_req,
    input  logic       gpu_req,
    input  logic       cpu_req,
    input  owner_t     rr_last,
    input  logic       force_cg,
    output logic [2:0] grant,
    output owner_t     owner
);

    logic cg_pending;

    always_comb begin
        grant      = '0;
        owner      = OWN_VGA;
        cg_pending = gpu_req | cpu_req;

        if (vga_req && !(force_cg && cg_pending)) begin
            grant[GNT_VGA] = 1'b1;
            owner          = OWN_VGA;
        end else if (cpu_req && gpu_req) begin
            // Tie: the one that did not win last time goes next.
            if (rr_last == OWN_CPU) begin
                grant[GNT_GPU] = 1'b1;
                owner          = OWN_GPU;
            end else begin
                grant[GNT_CPU] = 1'b1;
                owner          = OWN_CPU;
            end
        end else if (cpu_req) begin
            grant[GNT_CPU] = 1'b1;
            owner          = OWN_CPU;
        end else if (gpu_req) begin
            grant[GNT_GPU] = 1'b1;
            owner          = OWN_GPU;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Shares one external asynchronous SRAM between VGA scanout (read only), GPU
// and CPU. Each access: IDLE (arbitrate) -> RD/WR (strobe for READ_CYCLES /
// WRITE_CYCLES) -> DONE (one-cycle ack) -> IDLE. All outputs are registered.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   vga_req/addr/ack         : VGA read port
//   gpu_*, cpu_*             : read/write ports (we=1 write)
//   rdata                    : read data, valid in the ack cycle of a read and
//                              held until the next read completes
//   sram_addr, sram_dq_o     : SRAM address / write data
//   sram_dq_oe               : 1 = drive the data bus (tristate built above)
//   sram_dq_i                : SRAM read data
//   sram_ce/oen/wen          : active-low strobes
//
// Build option: define SRAM_ARB_STARVE_EN to cap consecutive VGA grants at
// VGA_MAX_BURST while CPU/GPU is waiting. Without it VGA is strictly first.
// -----------------------------------------------------------------------------
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 48,
    parameter int READ_CYCLES   = 2,
    parameter int WRITE_CYCLES  = 2,
    parameter int VGA_MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    input  logic              gpu_req,
    input  logic              gpu_we,
    input  logic [ADDR_W-1:0] gpu_addr,
    input  logic [DATA_W-1:0] gpu_wdata,
    output logic              gpu_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_ce,
    output logic              sram_oen,
    output logic              sram_wen
);

    localparam int CNT_MAX = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_CYCLES - 1);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    owner_t              rr_last_q, rr_last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ce_q, ce_d;
    logic                oen_q, oen_d;
    logic                wen_q, wen_d;
    logic                dq_oe_q, dq_oe_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   dq_o_q, dq_o_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [2:0]          ack_q, ack_d;

    logic [2:0]          grant;
    owner_t              sel_owner;
    logic                force_cg;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;

    sram_arb_sel u_sel (
        .vga_req  (vga_req),
        .gpu_req  (gpu_req),
        .cpu_req  (cpu_req),
        .rr_last  (rr_last_q),
        .force_cg (force_cg),
        .grant    (grant),
        .owner    (sel_owner)
    );

`ifdef SRAM_ARB_STARVE_EN
    localparam int RUN_W = (VGA_MAX_BURST < 1) ? 1 : $clog2(VGA_MAX_BURST + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(VGA_MAX_BURST);

    logic [RUN_W-1:0] vga_run_q, vga_run_d;

    assign force_cg = (vga_run_q == RUN_MAX);

    always_comb begin
        vga_run_d = vga_run_q;
        if (state_q == IDLE) begin
            if (grant[GNT_GPU] || grant[GNT_CPU] || !vga_req) begin
                vga_run_d = '0;
            end else if (grant[GNT_VGA] && (vga_run_q != RUN_MAX)) begin
                // Saturate: the limit stays armed until CPU/GPU is served.
                vga_run_d = vga_run_q + RUN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_run_q <= '0;
        end else begin
            vga_run_q <= vga_run_d;
        end
    end
`else
    assign force_cg = 1'b0;
`endif

    // Winner's request fields (only meaningful when grant is non-zero).
    always_comb begin
        win_we    = 1'b0;
        win_addr  = vga_addr;
        win_wdata = cpu_wdata;
        if (grant[GNT_CPU]) begin
            win_we    = cpu_we;
            win_addr  = cpu_addr;
            win_wdata = cpu_wdata;
        end else if (grant[GNT_GPU]) begin
            win_we    = gpu_we;
            win_addr  = gpu_addr;
            win_wdata = gpu_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        cnt_d     = cnt_q;
        ce_d      = ce_q;
        oen_d     = oen_q;
        wen_d     = wen_q;
        dq_oe_d   = dq_oe_q;
        addr_d    = addr_q;
        dq_o_d    = dq_o_q;
        rdata_d   = rdata_q;
        ack_d     = '0;

        case (state_q)
            IDLE: begin
                if (grant != 3'b000) begin
                    owner_d = sel_owner;
                    addr_d  = win_addr;
                    ce_d    = 1'b0;
                    if (!grant[GNT_VGA]) begin
                        rr_last_d = sel_owner;
                    end
                    if (win_we) begin
                        state_d = WR;
                        wen_d   = 1'b0;
                        dq_oe_d = 1'b1;
                        dq_o_d  = win_wdata;
                        cnt_d   = WR_LOAD;
                    end else begin
                        state_d = RD;
                        oen_d   = 1'b0;
                        cnt_d   = RD_LOAD;
                    end
                end
            end

            RD: begin
                if (cnt_q == '0) begin
                    rdata_d = sram_dq_i;
                    ce_d    = 1'b1;
                    oen_d   = 1'b1;
                    state_d = DONE;
                    // Ack is raised entering DONE so it is visible during DONE.
                    case (owner_q)
                        OWN_GPU: ack_d[GNT_GPU] = 1'b1;
                        OWN_CPU: ack_d[GNT_CPU] = 1'b1;
                        default: ack_d[GNT_VGA] = 1'b1;
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            WR: begin
                if (cnt_q == '0) begin
                    // Release strobes but keep driving data one more cycle
                    // so the SRAM sees stable data on the rising wen edge.
                    ce_d    = 1'b1;
                    wen_d   = 1'b1;
                    state_d = DONE;
                    case (owner_q)
                        OWN_GPU: ack_d[GNT_GPU] = 1'b1;
                        OWN_CPU: ack_d[GNT_CPU] = 1'b1;
                        default: ack_d[GNT_VGA] = 1'b1;
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            DONE: begin
                dq_oe_d = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_VGA;
            rr_last_q <= OWN_GPU;
            cnt_q     <= '0;
            ce_q      <= 1'b1;
            oen_q     <= 1'b1;
            wen_q     <= 1'b1;
            dq_oe_q   <= 1'b0;
            addr_q    <= '0;
            dq_o_q    <= '0;
            rdata_q   <= '0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            cnt_q     <= cnt_d;
            ce_q      <= ce_d;
            oen_q     <= oen_d;
            wen_q     <= wen_d;
            dq_oe_q   <= dq_oe_d;
            addr_q    <= addr_d;
            dq_o_q    <= dq_o_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
        end
    end

    assign vga_ack    = ack_q[GNT_VGA];
    assign gpu_ack    = ack_q[GNT_GPU];
    assign cpu_ack    = ack_q[GNT_CPU];
    assign rdata      = rdata_q;
    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce    = ce_q;
    assign sram_oen   = oen_q;
    assign sram_wen   = wen_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Directed scoreboard bench for sram_arbiter. Expected acks (owner and read
// data) are queued before stimulus; a monitor pops one entry per ack.
// Honors SRAM_ARB_STARVE_EN for the VGA starvation scenario.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 48;
    localparam int RC     = 2;
    localparam int WC     = 2;
    localparam int VMB    = 8;
    localparam int O_VGA  = 0;
    localparam int O_GPU  = 1;
    localparam int O_CPU  = 2;

    typedef struct {
        int              owner;
        bit              chk_data;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              vga_req = 1'b0;
    logic [ADDR_W-1:0] vga_addr = '0;
    logic              vga_ack;
    logic              gpu_req = 1'b0;
    logic              gpu_we = 1'b0;
    logic [ADDR_W-1:0] gpu_addr = '0;
    logic [DATA_W-1:0] gpu_wdata = '0;
    logic              gpu_ack;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_ack;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_o;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_i = '0;
    logic              sram_ce;
    logic              sram_oen;
    logic              sram_wen;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Strobe statistics accumulated by the monitor.
    int oen_lo = 0, wen_lo = 0, oe_hi = 0, dq_bad = 0;
    int contention = 0, bad_turn = 0, ack_total = 0;

    exp_t exp_q[$];
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

    sram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_CYCLES(RC),
        .WRITE_CYCLES(WC), .VGA_MAX_BURST(VMB)
    ) dut (
        .clk(clk), .rst(rst),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack),
        .gpu_req(gpu_req), .gpu_we(gpu_we), .gpu_addr(gpu_addr),
        .gpu_wdata(gpu_wdata), .gpu_ack(gpu_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .rdata(rdata), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
        .sram_ce(sram_ce), .sram_oen(sram_oen), .sram_wen(sram_wen)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Default SRAM contents: a known word at 0x10, an address pattern elsewhere.
    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        if (a == 20'h00010) return 48'h0123456789AB;
        return {28'hC0FFEE0, a};
    endfunction

    // SRAM model, evaluated on the falling edge so data is settled for the
    // DUT's next rising edge.
    always @(negedge clk) begin
        if (!sram_ce && !sram_wen) mem[sram_addr] = sram_dq_o;
        if (!sram_ce && !sram_oen)
            sram_dq_i = mem.exists(sram_addr) ? mem[sram_addr] : pat(sram_addr);
        else
            sram_dq_i = '0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int o, input bit c, input logic [DATA_W-1:0] d);
        exp_t e;
        e.owner = o; e.chk_data = c; e.data = d;
        return e;
    endfunction

    function automatic logic ack_of(input int who);
        case (who)
            O_VGA:   return vga_ack;
            O_GPU:   return gpu_ack;
            default: return cpu_ack;
        endcase
    endfunction

    task automatic drive(input int who, input logic r, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        case (who)
            O_VGA: begin vga_req = r; vga_addr = a; end
            O_GPU: begin gpu_req = r; gpu_we = we; gpu_addr = a; gpu_wdata = wd; end
            default: begin cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
        endcase
    endtask

    // Call just after a rising edge. Holds req until ack, then either drops it
    // or leaves it for the caller's next request in the cycle after ack.
    task automatic access(input int who, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd, input bit drop, output int lat);
        int start;
        bit got;
        drive(who, 1'b1, we, a, wd);
        start = cyc;
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (ack_of(who)) got = 1;
        end
        lat = cyc - start;
        if (!got) check("ack_timeout", 64'(who), 64'hFF);
        @(posedge clk); #1;
        if (drop) drive(who, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int lat, s0, s1, s2, s3, s4;
        exp_t e;

        fork
            begin
                #300000;
                $display("FAIL watchdog expired at cycle %0d", cyc);
                $fatal(1, "watchdog");
            end
        join_none

        // Monitor: pops the scoreboard on each ack and gathers strobe stats.
        fork
            begin
                logic prev_oen, prev_oe;
                logic [DATA_W-1:0] prev_dq;
                int nack;
                prev_oen = 1'b1; prev_oe = 1'b0; prev_dq = '0;
                forever begin
                    @(negedge clk);
                    nack = int'(vga_ack) + int'(gpu_ack) + int'(cpu_ack);
                    ack_total += nack;
                    if (!rst) begin
                        if (!sram_oen) oen_lo++;
                        if (!sram_wen) wen_lo++;
                        if (sram_dq_oe) oe_hi++;
                        if (sram_dq_oe && prev_oe && sram_dq_o != prev_dq) dq_bad++;
                        if (sram_dq_oe && !sram_oen) contention++;
                        if (!sram_oen && prev_oen && prev_oe) bad_turn++;
                        if (nack != 0) begin
                            check("ack_onehot", 64'(nack), 64'd1);
                            if (exp_q.size() == 0) begin
                                check("unexpected_ack", 64'(nack), 64'd0);
                            end else begin
                                e = exp_q.pop_front();
                                check("ack_owner", {61'd0, cpu_ack, gpu_ack, vga_ack},
                                      64'(1) << e.owner);
                                if (e.chk_data) check("rdata", 64'(rdata), 64'(e.data));
                                $display("ack owner=%0d rdata=%h cycle=%0d", e.owner, rdata, cyc);
                            end
                        end
                    end
                    prev_oen = sram_oen; prev_oe = sram_dq_oe; prev_dq = sram_dq_o;
                end
            end
        join_none

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ce", 64'(sram_ce), 64'd1);
        check("rst_oen", 64'(sram_oen), 64'd1);
        check("rst_wen", 64'(sram_wen), 64'd1);
        check("rst_dq_oe", 64'(sram_dq_oe), 64'd0);
        check("rst_addr", 64'(sram_addr), 64'd0);
        check("rst_dq_o", 64'(sram_dq_o), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_acks", {61'd0, cpu_ack, gpu_ack, vga_ack}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // CPU read of the preloaded word.
        exp_q.push_back(mk(O_CPU, 1, 48'h0123456789AB));
        s0 = oen_lo;
        access(O_CPU, 1'b0, 20'h00010, '0, 1, lat);
        check("cpu_rd_latency", 64'(lat), 64'(RC + 1));
        check("cpu_rd_oen_cycles", 64'(oen_lo - s0), 64'(RC));

        // GPU write; rdata must keep the last read value.
        exp_q.push_back(mk(O_GPU, 1, 48'h0123456789AB));
        s0 = wen_lo; s1 = oe_hi; s2 = dq_bad;
        access(O_GPU, 1'b1, 20'h00020, 48'hA5A5A5A5A5A5, 1, lat);
        check("gpu_wr_latency", 64'(lat), 64'(WC + 1));
        check("gpu_wr_wen_cycles", 64'(wen_lo - s0), 64'(WC));
        check("gpu_wr_oe_cycles", 64'(oe_hi - s1), 64'(WC + 1));
        check("gpu_wr_dq_stable", 64'(dq_bad - s2), 64'd0);

        // Read back the written word.
        exp_q.push_back(mk(O_CPU, 1, 48'hA5A5A5A5A5A5));
        access(O_CPU, 1'b0, 20'h00020, '0, 1, lat);

        // CPU write immediately followed by a VGA read of the same word.
        exp_q.push_back(mk(O_CPU, 1, 48'hA5A5A5A5A5A5));
        exp_q.push_back(mk(O_VGA, 1, 48'h123456789ABC));
        s3 = bad_turn;
        fork
            access(O_CPU, 1'b1, 20'h00030, 48'h123456789ABC, 1, s4);
            begin
                int l2;
                @(posedge clk); #1;
                access(O_VGA, 1'b0, 20'h00030, '0, 1, l2);
            end
        join
        check("wr_rd_turnaround", 64'(bad_turn - s3), 64'd0);

        // Reset in the second RD cycle: access lost, no ack.
        s0 = ack_total;
        drive(O_CPU, 1'b1, 1'b0, 20'h00010, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        drive(O_CPU, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_ce", 64'(sram_ce), 64'd1);
        check("midrst_oen", 64'(sram_oen), 64'd1);
        check("midrst_wen", 64'(sram_wen), 64'd1);
        check("midrst_dq_oe", 64'(sram_dq_oe), 64'd0);
        check("midrst_rdata", 64'(rdata), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_ack", 64'(ack_total - s0), 64'd0);
        exp_q.push_back(mk(O_GPU, 1, 48'h0123456789AB));
        access(O_GPU, 1'b0, 20'h00010, '0, 1, lat);
        check("post_rst_latency", 64'(lat), 64'(RC + 1));

        // Simultaneous VGA/CPU/GPU: VGA, then CPU/GPU alternating from CPU.
        do_reset();
        exp_q.push_back(mk(O_VGA, 1, 48'hC0FFEE000100));
        exp_q.push_back(mk(O_CPU, 1, 48'hC0FFEE000201));
        exp_q.push_back(mk(O_GPU, 1, 48'hC0FFEE000301));
        exp_q.push_back(mk(O_CPU, 1, 48'hC0FFEE000202));
        exp_q.push_back(mk(O_GPU, 1, 48'hC0FFEE000302));
        fork
            access(O_VGA, 1'b0, 20'h00100, '0, 1, s0);
            begin
                int l;
                access(O_CPU, 1'b0, 20'h00201, '0, 0, l);
                access(O_CPU, 1'b0, 20'h00202, '0, 1, l);
            end
            begin
                int l;
                access(O_GPU, 1'b0, 20'h00301, '0, 0, l);
                access(O_GPU, 1'b0, 20'h00302, '0, 1, l);
            end
        join

        // VGA held continuously with a CPU request pending.
        do_reset();
`ifdef SRAM_ARB_STARVE_EN
        for (int i = 0; i < VMB; i++)
            exp_q.push_back(mk(O_VGA, 1, {28'hC0FFEE0, 20'(20'h00400 + i)}));
        exp_q.push_back(mk(O_CPU, 1, 48'hC0FFEE000500));
        for (int i = VMB; i < VMB + 4; i++)
            exp_q.push_back(mk(O_VGA, 1, {28'hC0FFEE0, 20'(20'h00400 + i)}));
        s1 = VMB + 4;
`else
        for (int i = 0; i < 100; i++)
            exp_q.push_back(mk(O_VGA, 1, {28'hC0FFEE0, 20'(20'h00400 + i)}));
        exp_q.push_back(mk(O_CPU, 1, 48'hC0FFEE000500));
        s1 = 100;
`endif
        fork
            begin
                int l;
                for (int i = 0; i < s1; i++)
                    access(O_VGA, 1'b0, 20'(20'h00400 + i), '0, i == s1 - 1, l);
            end
            access(O_CPU, 1'b0, 20'h00500, '0, 1, s2);
        join

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("bus_contention", 64'(contention), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
